// File: rtl/gpio_ctrl_pkg.sv
// Shared bus widths, register offsets and bus FSM encoding for the GPIO controller.
package gpio_ctrl_pkg;
    localparam int MRAV_ADDR_WIDTH = 32;
    localparam int MRAV_DATA_WIDTH = 32;

    localparam logic [2:0] GPIO_REG_DATA_OUT = 3'd0;
    localparam logic [2:0] GPIO_REG_DIR      = 3'd1;
    localparam logic [2:0] GPIO_REG_DATA_IN  = 3'd2;
    localparam logic [2:0] GPIO_REG_IRQ_EN   = 3'd3;
    localparam logic [2:0] GPIO_REG_IRQ_PEND = 3'd4;
    localparam logic [2:0] GPIO_REG_IRQ_POL  = 3'd5;

    localparam int GPIO_MAX_SYNC_STAGES = 4;

    typedef enum logic {GPIO_IDLE, GPIO_ACK} gpio_bus_state_t;
endpackage

// File: rtl/gpio_ctrl_sync.sv
// WIDTH-wide, SYNC_STAGES-deep input synchroniser; dout is the last stage.
module gpio_sync #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [SYNC_STAGES-1:0][WIDTH-1:0] stg;

    always_ff @(posedge clk) begin
        if (rst) stg <= '0;
        else     stg <= {stg[SYNC_STAGES-2:0], din};
    end

    assign dout = stg[SYNC_STAGES-1];
endmodule

// File: rtl/gpio_ctrl.sv
// Parametrised GPIO controller: direction/data registers, synchronised inputs and,
// with MRAV_GPIO_IRQ_EN defined, per-pin edge interrupts (enable, sticky pending, polarity).
module gpio_ctrl
    import gpio_ctrl_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_LSB    = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       read,
    input  logic                       write,
    output logic                       read_done,
    output logic                       write_done,
    input  logic [MRAV_ADDR_WIDTH-1:0] addr,
    input  logic [MRAV_DATA_WIDTH-1:0] cpu_data_out,
    output logic [MRAV_DATA_WIDTH-1:0] cpu_data_in,
    output logic [WIDTH-1:0]           external_output,
    output logic [WIDTH-1:0]           external_oe,
    input  logic [WIDTH-1:0]           external_input,
    output logic                       irq
);
    gpio_bus_state_t state, state_nxt;
    logic                       ack_wr;
    logic [2:0]                 off;
    logic [WIDTH-1:0]           wdata, data_out_q, dir_q, din;
    logic                       wr_en, rd_en;
    logic [MRAV_DATA_WIDTH-1:0] rdata;
    logic                       unused_bits;

    assign off         = addr[ADDR_LSB+2:ADDR_LSB];
    assign wdata       = cpu_data_out[WIDTH-1:0];
    assign wr_en       = (state == GPIO_IDLE) && write;
    assign rd_en       = (state == GPIO_IDLE) && read && !write;
    assign unused_bits = ^{cpu_data_out, addr};

    gpio_sync #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (external_input),
        .dout (din)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= GPIO_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            GPIO_IDLE: if (write || read) state_nxt = GPIO_ACK;
            GPIO_ACK:  state_nxt = GPIO_IDLE;
            default:   state_nxt = GPIO_IDLE;
        endcase
    end

    always_comb begin
        read_done  = 1'b0;
        write_done = 1'b0;
        if (state == GPIO_ACK) begin
            write_done = ack_wr;
            read_done  = !ack_wr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_wr      <= 1'b0;
            data_out_q  <= '0;
            dir_q       <= '0;
            cpu_data_in <= '0;
        end else begin
            if (state == GPIO_IDLE) ack_wr <= write;
            if (wr_en) begin
                case (off)
                    GPIO_REG_DATA_OUT: data_out_q <= wdata;
                    GPIO_REG_DIR:      dir_q      <= wdata;
                    default: ;
                endcase
            end
            if (rd_en) cpu_data_in <= rdata;
        end
    end

    assign external_output = data_out_q;
    assign external_oe     = dir_q;

`ifdef MRAV_GPIO_IRQ_EN
    logic [WIDTH-1:0] irq_en_q, irq_pol_q, irq_pend_q, prev_q, evt, w1c;
    logic             irq_q;

    assign evt = (din & ~prev_q & ~irq_pol_q) | (~din & prev_q & irq_pol_q);
    assign w1c = (wr_en && off == GPIO_REG_IRQ_PEND) ? wdata : '0;

    // A fresh event outranks a W1C of the same bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en_q   <= '0;
            irq_pol_q  <= '0;
            irq_pend_q <= '0;
            prev_q     <= '0;
            irq_q      <= 1'b0;
        end else begin
            prev_q     <= din;
            irq_pend_q <= (irq_pend_q & ~w1c) | evt;
            irq_q      <= |(irq_pend_q & irq_en_q);
            if (wr_en) begin
                case (off)
                    GPIO_REG_IRQ_EN:  irq_en_q  <= wdata;
                    GPIO_REG_IRQ_POL: irq_pol_q <= wdata;
                    default: ;
                endcase
            end
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        case (off)
            GPIO_REG_DATA_OUT: rdata[WIDTH-1:0] = data_out_q;
            GPIO_REG_DIR:      rdata[WIDTH-1:0] = dir_q;
            GPIO_REG_DATA_IN:  rdata[WIDTH-1:0] = din;
`ifdef MRAV_GPIO_IRQ_EN
            GPIO_REG_IRQ_EN:   rdata[WIDTH-1:0] = irq_en_q;
            GPIO_REG_IRQ_PEND: rdata[WIDTH-1:0] = irq_pend_q;
            GPIO_REG_IRQ_POL:  rdata[WIDTH-1:0] = irq_pol_q;
`endif
            default: ;
        endcase
    end
endmodule

// File: tb/tb_gpio_ctrl.sv
// Self-checking bench for gpio_ctrl: directed cases plus random register/pin traffic
// checked against a register-level model; irq checks follow MRAV_GPIO_IRQ_EN.
module tb_gpio_ctrl;
    import gpio_ctrl_pkg::*;

    localparam int W  = 8;
    localparam int SS = 3;

    logic          clk = 1'b0, rst = 1'b1, read = 1'b0, write = 1'b0;
    logic          read_done, write_done, irq;
    logic [31:0]   addr = '0, cpu_data_out = '0, cpu_data_in;
    logic [W-1:0]  external_output, external_oe;
    logic [W-1:0]  external_input = '0;

    int n_tests = 0, n_fail = 0;
    logic [W-1:0] m_out, m_dir, m_pins, m_en, m_pend, m_pol;

    gpio_ctrl #(.WIDTH(W), .SYNC_STAGES(SS), .ADDR_LSB(0)) dut (
        .clk(clk), .rst(rst), .read(read), .write(write),
        .read_done(read_done), .write_done(write_done),
        .addr(addr), .cpu_data_out(cpu_data_out), .cpu_data_in(cpu_data_in),
        .external_output(external_output), .external_oe(external_oe),
        .external_input(external_input), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_out = '0; m_dir = '0; m_pins = '0; m_en = '0; m_pend = '0; m_pol = '0;
    endtask

    function automatic logic [31:0] model_rd(input logic [2:0] off);
        logic [31:0] r;
        r = '0;
        case (off)
            3'd0: r[W-1:0] = m_out;
            3'd1: r[W-1:0] = m_dir;
            3'd2: r[W-1:0] = m_pins;
`ifdef MRAV_GPIO_IRQ_EN
            3'd3: r[W-1:0] = m_en;
            3'd4: r[W-1:0] = m_pend;
            3'd5: r[W-1:0] = m_pol;
`endif
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic model_wr(input logic [2:0] off, input logic [31:0] d);
        case (off)
            3'd0: m_out = d[W-1:0];
            3'd1: m_dir = d[W-1:0];
`ifdef MRAV_GPIO_IRQ_EN
            3'd3: m_en  = d[W-1:0];
            3'd4: m_pend = m_pend & ~d[W-1:0];
            3'd5: m_pol = d[W-1:0];
`endif
            default: ;
        endcase
    endtask

    // Pins moved from m_pins to nv: rising or falling per polarity marks pending.
    task automatic apply_pins(input logic [W-1:0] nv);
        logic [W-1:0] evt;
        evt = (nv & ~m_pins & ~m_pol) | (~nv & m_pins & m_pol);
`ifdef MRAV_GPIO_IRQ_EN
        m_pend = m_pend | evt;
`endif
        m_pins = nv;
    endtask

    function automatic logic exp_irq();
`ifdef MRAV_GPIO_IRQ_EN
        return |(m_pend & m_en);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_outs(input string tag);
        chk({tag, "_out"}, 32'(external_output), 32'(m_out));
        chk({tag, "_oe"},  32'(external_oe),     32'(m_dir));
        chk({tag, "_irq"}, 32'(irq),             32'(exp_irq()));
    endtask

    task automatic settle(input logic [W-1:0] nv);
        external_input = nv;
        tick(SS + 3);
        apply_pins(nv);
        chk("settle_irq", 32'(irq), 32'(exp_irq()));
    endtask

    task automatic bus_write(input logic [2:0] off, input logic [31:0] d);
        addr = {29'd0, off}; cpu_data_out = d; write = 1'b1;
        tick();
        chk("wr_done", 32'(write_done), 32'd1);
        chk("wr_no_rdone", 32'(read_done), 32'd0);
        write = 1'b0;
        tick();
        chk("wr_done_end", 32'(write_done), 32'd0);
        model_wr(off, d);
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] off);
        logic [31:0] exp;
        exp = model_rd(off);
        addr = {29'd0, off}; read = 1'b1;
        tick();
        chk({tag, "_done"}, 32'(read_done), 32'd1);
        chk(tag, cpu_data_in, exp);
        read = 1'b0;
        tick();
        chk({tag, "_done_end"}, 32'(read_done), 32'd0);
        chk({tag, "_hold"}, cpu_data_in, exp);
    endtask

    initial begin
        logic [W-1:0] nv;
        model_reset();
        tick(2);
        chk("rst_rdone", 32'(read_done), 32'd0);
        chk("rst_wdone", 32'(write_done), 32'd0);
        chk("rst_rdata", cpu_data_in, 32'd0);
        check_outs("rst");
        rst = 1'b0;
        tick();

        rd_chk("rst_dir", 3'd1);
        rd_chk("rst_dout", 3'd0);
        rd_chk("rst_pend", 3'd4);
        check_outs("post_rst");

        bus_write(3'd0, 32'hFFFF_FFA5);
        bus_write(3'd1, 32'h0000_000F);
        chk("dout_pins", 32'(external_output), 32'h0000_00A5);
        chk("dir_pins", 32'(external_oe), 32'h0000_000F);
        rd_chk("rd_dout", 3'd0);
        rd_chk("rd_dir", 3'd1);

        // Read one edge before the synchroniser delivers, then exactly on it.
        external_input = 8'h3C;
        tick(SS - 1);
        rd_chk("din_early", 3'd2);
        tick(SS + 3);
        apply_pins(8'h3C);
        settle(8'h00);
        external_input = 8'h3C;
        tick(SS);
        apply_pins(8'h3C);
        rd_chk("din_exact", 3'd2);
        tick(3);
        check_outs("din");

`ifdef MRAV_GPIO_IRQ_EN
        bus_write(3'd4, 32'hFF);
        bus_write(3'd3, 32'h01);
        bus_write(3'd5, 32'h00);
        settle(m_pins | 8'h01);
        chk("irq_rise", 32'(irq), 32'd1);
        rd_chk("pend_b0", 3'd4);
        bus_write(3'd4, 32'h01);
        chk("irq_clr", 32'(irq), 32'd0);
        settle(m_pins | 8'h02);
        chk("irq_masked", 32'(irq), 32'd0);
        rd_chk("pend_b1", 3'd4);

        bus_write(3'd5, 32'h04);
        settle(m_pins & ~8'h04);
        settle(m_pins | 8'h04);
        rd_chk("pend_b2_pre", 3'd4);
        nv = m_pins & ~8'h04;
        external_input = nv;
        tick(SS);
        bus_write(3'd4, 32'h04);
        apply_pins(nv);
        rd_chk("pend_set_wins", 3'd4);
        tick(2);
        check_outs("setwins");
`endif

        addr = {29'd0, 3'd1}; cpu_data_out = 32'h3C; read = 1'b1; write = 1'b1;
        tick();
        chk("rw_wdone", 32'(write_done), 32'd1);
        chk("rw_rdone", 32'(read_done), 32'd0);
        read = 1'b0; write = 1'b0;
        tick();
        model_wr(3'd1, 32'h3C);
        rd_chk("rw_dir", 3'd1);

        for (int i = 0; i < 120; i++) begin
            logic [2:0] off;
            off = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 2))
                0: bus_write(off, $urandom);
                1: rd_chk("rnd_rd", off);
                default: settle(W'($urandom));
            endcase
            check_outs("rnd");
        end

        settle(8'h00);
        bus_write(3'd0, 32'h77);
        addr = '0; cpu_data_out = 32'hFF; write = 1'b1; rst = 1'b1;
        tick();
        chk("rstA_wdone", 32'(write_done), 32'd0);
        chk("rstA_out", 32'(external_output), 32'd0);
        write = 1'b0; rst = 1'b0;
        model_reset();
        tick();
        chk("rstA_wdone2", 32'(write_done), 32'd0);
        check_outs("rstA");

        bus_write(3'd1, 32'hC3);
        rd_chk("pre_rstB", 3'd1);
        addr = '0; cpu_data_out = 32'h5A; write = 1'b1;
        tick();
        chk("rstB_ack", 32'(write_done), 32'd1);
        chk("rstB_wr", 32'(external_output), 32'h5A);
        rst = 1'b1; write = 1'b0;
        tick();
        rst = 1'b0;
        model_reset();
        chk("rstB_wdone", 32'(write_done), 32'd0);
        chk("rstB_rdone", 32'(read_done), 32'd0);
        chk("rstB_rdata", cpu_data_in, 32'd0);
        check_outs("rstB");
        tick();
        chk("rstB_wdone2", 32'(write_done), 32'd0);
        rd_chk("rstB_dout", 3'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/gpio_ctrl.md
Name: gpio_ctrl

Overview:
- Parametrised GPIO controller for the MRAV SoC bus, and the successor to the fixed 8-bit output-only GPIO.
- Provides WIDTH bidirectional pins with a per-pin direction register.
- Input pins pass through a multi-stage synchroniser and feed per-pin edge detection with a maskable, sticky interrupt.
- Bus transactions use a registered one-cycle acknowledge, so read data is stable when the done strobe asserts.

Parameters:
- WIDTH, 8: number of GPIO pins; legal range 1..MRAV_DATA_WIDTH.
- SYNC_STAGES, 2: flip-flop stages on each input pin; legal range 2..4.
- ADDR_LSB, 0: lowest address bit used for register decode; offsets come from addr[ADDR_LSB+2:ADDR_LSB].

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- read  in  1  bus read request, held by the master until read_done.
- write  in  1  bus write request, held by the master until write_done.
- read_done  out  1  one-cycle read acknowledge.
- write_done  out  1  one-cycle write acknowledge.
- addr  in  MRAV_ADDR_WIDTH  register address.
- cpu_data_out  in  MRAV_DATA_WIDTH  write data from the CPU.
- cpu_data_in  out  MRAV_DATA_WIDTH  read data to the CPU; zero-extended above WIDTH.
- external_output  out  WIDTH  pin output values.
- external_oe  out  WIDTH  per-pin output enable; 1 = drive.
- external_input  in  WIDTH  asynchronous pin inputs.
- irq  out  1  level interrupt: OR of (IRQ_PEND & IRQ_EN).

Behaviour:
- Reset: one clock and one reset only. Reset is synchronous and active-high (rst sampled on the posedge of clk).
- All registers are 0 after reset, including the synchroniser stages and the edge-history register. Therefore read_done=0, write_done=0, cpu_data_in=0, external_output=0, external_oe=0 (all pins inputs) and irq=0.
- Register map (offset: name, access):
  - 0: DATA_OUT, RW.
  - 1: DIR, RW; 1 = output.
  - 2: DATA_IN, RO; synchronised pin values.
  - 3: IRQ_EN, RW.
  - 4: IRQ_PEND, read / write-1-to-clear.
  - 5: IRQ_POL, RW; 0 = rising edge, 1 = falling edge.
  - 6, 7: reserved; read 0, writes ignored but still acknowledged.
- Bus FSM, states IDLE and ACK:
  - IDLE: if write=1, perform the register update at this clock edge and go to ACK. Else if read=1, register the selected value into cpu_data_in and go to ACK.
  - ACK: assert exactly one of write_done / read_done for one cycle, then return to IDLE unconditionally. Requests seen while in ACK are ignored.
  - Result: each transaction takes 2 cycles, and the master drops its request in the done cycle.
  - read and write high together: treated as a write; only write_done is pulsed.
  - cpu_data_in holds its last read value outside read_done.
- Writes use cpu_data_out[WIDTH-1:0]; the upper bits are ignored.
- Synchroniser: DATA_IN = the last of the SYNC_STAGES stages, so pin-to-DATA_IN latency is SYNC_STAGES cycles.
- Edge detection:
  - prev <= DATA_IN every cycle.
  - Rising event = DATA_IN & ~prev; falling event = ~DATA_IN & prev; IRQ_POL selects one per pin.
  - Detection runs on all pins regardless of DIR.
- IRQ_PEND update order: next = (PEND & ~w1c_mask) | event. A new event in the same cycle as a W1C of that bit leaves the bit set (set wins).
- IRQ_EN does not gate detection, only irq. Enabling a pin with PEND already 1 raises irq on the next cycle.
- irq is registered: it asserts one cycle after PEND & EN becomes nonzero.
- Reset mid-transaction: the FSM returns to IDLE, no done pulse is issued, and the write does not happen unless its edge preceded reset.

Optional Feature:
- Macro: MRAV_GPIO_IRQ_EN.
- Defined: IRQ_EN, IRQ_PEND, IRQ_POL, the edge logic and irq exist as above.
- Undefined: those registers and the edge logic are removed. Offsets 3–5 read 0, writes to them are acknowledged and ignored, and irq is tied to 0. The synchroniser and DATA_IN remain.

Decomposition:
- Package gpio_ctrl_pkg holds:
  - register offset localparams GPIO_REG_DATA_OUT..GPIO_REG_IRQ_POL;
  - typedef enum logic {GPIO_IDLE, GPIO_ACK} gpio_bus_state_t;
  - GPIO_MAX_SYNC_STAGES.
- One sub-module, gpio_sync: a WIDTH-wide, SYNC_STAGES-deep synchroniser with synchronous active-high reset.

Test Plan:
- Reset then read DIR, DATA_OUT and IRQ_PEND -> each returns 0x0000; external_oe=0 and irq=0 throughout.
- Write DATA_OUT=0xA5 and DIR=0x0F, then read both back -> external_output=0xA5 and external_oe=0x0F. write_done pulses 1 cycle after write rises. Read data is 0x00A5 / 0x000F, valid in the read_done cycle.
- Set external_input 0x00->0x3C -> DATA_IN reads 0x003C; the value appears exactly SYNC_STAGES cycles after the pin change.
- Macro on: IRQ_EN=0x01 and IRQ_POL=0, drive pin0 0->1 -> IRQ_PEND bit0=1 and irq=1. Then write IRQ_PEND=0x01 -> irq=0 the cycle after the clear. A pin1 edge with IRQ_EN bit1=0 sets PEND bit1 but leaves irq=0.
- A falling edge lands on the clock edge where W1C clears the same bit -> PEND bit stays 1. read and write asserted together -> register written, only write_done pulses.
- Assert rst while in the ACK state -> no done pulse and all outputs 0 next cycle. Macro off: offset 4 reads 0 and irq stays 0 under pin toggling.
